// File: rtl/bios_loader.sv
// bios_loader: byte-stream command decoder with word-wide RAM access,
// CPU reset control and a pass-through mode to the CPU once booted.
module bios_loader #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned AUTO_INC     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   output logic                    o_cpu_rst,
   output logic                    o_booted,
   output logic                    o_read_req,
   output logic [ADDR_WIDTH-1:0]   o_read_addr,
   input  logic [DATA_WIDTH-1:0]   i_read_data,
   output logic                    o_write_enable,
   output logic [DATA_WIDTH/8-1:0] o_byte_enable,
   output logic [ADDR_WIDTH-1:0]   o_write_addr,
   output logic [DATA_WIDTH-1:0]   o_write_data,
   input  logic [7:0]              i_data,
   input  logic                    i_valid,
   output logic                    o_in_ready,
   output logic [7:0]              o_data,
   output logic                    o_valid,
   input  logic                    i_out_ready,
   output logic [7:0]              o_cpu_rx_data,
   output logic                    o_cpu_rx_valid,
   input  logic                    i_cpu_rx_ready,
   input  logic [7:0]              i_cpu_tx_data,
   input  logic                    i_cpu_tx_valid,
   output logic                    o_cpu_tx_ready
);

   localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
   localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
   localparam int unsigned ARG_W0     = (DATA_WIDTH > ADDR_BYTES * 8) ? DATA_WIDTH : ADDR_BYTES * 8;
   localparam int unsigned ARG_W      = (ARG_W0 > 16) ? ARG_W0 : 16;
   localparam int unsigned CNT_M1     = (DATA_BYTES > ADDR_BYTES) ? DATA_BYTES : ADDR_BYTES;
   localparam int unsigned CNT_M2     = (RST_CYCLES > READ_LATENCY) ? RST_CYCLES : READ_LATENCY;
   localparam int unsigned CNT_MAX    = (CNT_M1 > CNT_M2) ? CNT_M1 : CNT_M2;
   localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_BOOT    = 8'h01;
   localparam logic [7:0] OP_RST     = 8'h02;
   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_WRITE   = 8'h04;
   localparam logic [7:0] OP_SETADDR = 8'h05;
   localparam logic [7:0] BYTE_ACK   = 8'h06;
   localparam logic [7:0] BYTE_NAK   = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARGS,
      S_WRITE,
      S_RREQ,
      S_RWAIT,
      S_SEND,
      S_ACK,
      S_PULSE
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [7:0]              op_q, op_d;
   logic [ARG_W-1:0]        arg_q, arg_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              reply_q, reply_d;
   logic                    booted_q, booted_d;
   logic                    cpu_rst_q, cpu_rst_d;

   logic [ARG_W-1:0]        arg_shift;
   logic [ADDR_BYTES*8-1:0] addr_bytes;
   logic [ADDR_WIDTH-1:0]   addr_next;
   logic [CNT_W-1:0]        last_arg;
   logic                    fsm_active;

   // State register with synchronous reset and cycle enable folded into _d
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         arg_q     <= '0;
         word_q    <= '0;
         addr_q    <= '0;
         reply_q   <= '0;
         booted_q  <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         arg_q     <= arg_d;
         word_q    <= word_d;
         addr_q    <= addr_d;
         reply_q   <= reply_d;
         booted_q  <= booted_d;
         cpu_rst_q <= cpu_rst_d;
      end
   end

   // Command decode and sequencing; frozen when disabled or booted
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      arg_d     = arg_q;
      word_d    = word_q;
      addr_d    = addr_q;
      reply_d   = reply_q;
      booted_d  = booted_q;
      cpu_rst_d = cpu_rst_q;

      // Payload bytes enter at the top, so after N bytes the argument sits
      // LSB-first in the top N bytes of the register.
      arg_shift  = {i_data, arg_q[ARG_W-1:8]};
      addr_bytes = arg_shift[ARG_W-1 -: ADDR_BYTES*8];
      addr_next  = (AUTO_INC != 0) ? addr_q + ADDR_WIDTH'(DATA_BYTES) : addr_q;
      last_arg   = (op_q == OP_WRITE) ? CNT_W'(DATA_BYTES - 1) : CNT_W'(ADDR_BYTES - 1);
      fsm_active = clk_en & ~booted_q;

      if (fsm_active) begin
         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  op_d  = i_data;
                  cnt_d = '0;
                  case (i_data)
                     OP_NOP: ;
                     OP_BOOT: begin
                        booted_d  = 1'b1;
                        cpu_rst_d = 1'b0;
                     end
                     OP_RST: begin
                        cpu_rst_d = 1'b1;
                        state_d   = S_PULSE;
                     end
                     OP_READ:    state_d = S_RREQ;
                     OP_WRITE,
                     OP_SETADDR: state_d = S_ARGS;
                     default: begin
                        reply_d = BYTE_NAK;
                        state_d = S_ACK;
                     end
                  endcase
               end
            end
            S_ARGS: begin
               if (i_valid) begin
                  arg_d = arg_shift;
                  if (cnt_q == last_arg) begin
                     cnt_d = '0;
                     if (op_q == OP_WRITE) begin
                        word_d  = arg_shift[ARG_W-1 -: DATA_WIDTH];
                        state_d = S_WRITE;
                     end else begin
                        addr_d  = addr_bytes[ADDR_WIDTH-1:0];
                        reply_d = BYTE_ACK;
                        state_d = S_ACK;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            S_WRITE: begin
               addr_d  = addr_next;
               reply_d = BYTE_ACK;
               state_d = S_ACK;
            end
            S_RREQ: begin
               cnt_d   = '0;
               state_d = S_RWAIT;
            end
            S_RWAIT: begin
               if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                  word_d  = i_read_data;
                  addr_d  = addr_next;
                  cnt_d   = '0;
                  state_d = S_SEND;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SEND: begin
               if (i_out_ready) begin
                  word_d = word_q >> 8;
                  if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                     cnt_d   = '0;
                     state_d = S_IDLE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            S_ACK: begin
               if (i_out_ready) state_d = S_IDLE;
            end
            S_PULSE: begin
               if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                  cnt_d     = '0;
                  cpu_rst_d = ~booted_q;
                  state_d   = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output muxing: FSM-driven until booted, then a straight CPU pass-through
   always_comb begin
      o_cpu_rst      = cpu_rst_q;
      o_booted       = booted_q;
      o_read_req     = clk_en & ~booted_q & (state_q == S_RREQ);
      o_write_enable = clk_en & ~booted_q & (state_q == S_WRITE);
      o_byte_enable  = {DATA_BYTES{o_write_enable}};
      o_read_addr    = addr_q;
      o_write_addr   = addr_q;
      o_write_data   = word_q;
      o_in_ready     = ~booted_q & ((state_q == S_IDLE) | (state_q == S_ARGS));
      o_valid        = (state_q == S_SEND) | (state_q == S_ACK);
      o_data         = '0;
      if (state_q == S_SEND) o_data = word_q[7:0];
      else if (state_q == S_ACK) o_data = reply_q;
      o_cpu_rx_data  = '0;
      o_cpu_rx_valid = 1'b0;
      o_cpu_tx_ready = 1'b0;
      if (booted_q) begin
         o_in_ready     = i_cpu_rx_ready;
         o_valid        = i_cpu_tx_valid;
         o_data         = i_cpu_tx_data;
         o_cpu_tx_ready = i_out_ready;
         o_cpu_rx_data  = i_data;
         o_cpu_rx_valid = i_valid;
      end
   end

endmodule

// File: tb/tb_bios_loader.sv
// Self-checking bench for bios_loader: directed table, corner sequences,
// and a randomized command stream compared against a command-level model.
module tb_bios_loader;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 2;
   localparam int unsigned RC = 16;

   logic          clk = 0;
   logic          rst = 1;
   logic          clk_en = 1;
   logic          o_cpu_rst, o_booted, o_read_req, o_write_enable;
   logic [AW-1:0] o_read_addr, o_write_addr;
   logic [DW-1:0] i_read_data = '0;
   logic [3:0]    o_byte_enable;
   logic [DW-1:0] o_write_data;
   logic [7:0]    i_data = '0;
   logic          i_valid = 0;
   logic          o_in_ready;
   logic [7:0]    o_data;
   logic          o_valid;
   logic          i_out_ready = 1;
   logic [7:0]    o_cpu_rx_data;
   logic          o_cpu_rx_valid;
   logic          i_cpu_rx_ready = 1;
   logic [7:0]    i_cpu_tx_data = '0;
   logic          i_cpu_tx_valid = 0;
   logic          o_cpu_tx_ready;

   bios_loader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
      .RST_CYCLES(RC), .AUTO_INC(1)
   ) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .o_cpu_rst(o_cpu_rst), .o_booted(o_booted),
      .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
      .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
      .o_write_addr(o_write_addr), .o_write_data(o_write_data),
      .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready),
      .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
      .o_cpu_rx_data(o_cpu_rx_data), .o_cpu_rx_valid(o_cpu_rx_valid),
      .i_cpu_rx_ready(i_cpu_rx_ready),
      .i_cpu_tx_data(i_cpu_tx_data), .i_cpu_tx_valid(i_cpu_tx_valid),
      .o_cpu_tx_ready(o_cpu_tx_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by test

   logic [7:0]  tx_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [3:0]  wr_be_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] ram [logic [31:0]];

   logic        pv [RL+1];
   logic [31:0] pa [RL+1];

   function automatic logic [31:0] bg(input logic [31:0] a);
      return a ^ 32'hC3C3_5A5A;
   endfunction

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return bg(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Sink monitor and RAM model: everything sampled on the falling edge
   initial begin
      for (int k = 0; k <= RL; k++) begin pv[k] = 0; pa[k] = '0; end
      forever begin
         @(negedge clk);
         if (o_valid && i_out_ready && clk_en && !o_booted) tx_q.push_back(o_data);
         if (o_write_enable) begin
            wr_addr_q.push_back(o_write_addr);
            wr_data_q.push_back(o_write_data);
            wr_be_q.push_back(o_byte_enable);
            ram[o_write_addr] = o_write_data;
         end
         if (o_read_req) rd_q.push_back(o_read_addr);
         for (int k = RL; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
         pv[0] = o_read_req;
         pa[0] = o_read_addr;
         i_read_data = pv[RL] ? ram_rd(pa[RL]) : $urandom;
      end
   end

   // Host TX backpressure
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 0) i_out_ready = 1;
         else if (ready_mode == 1) i_out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      @(posedge clk); #1;
      tx_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); rd_q.delete();
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst = 1; i_valid = 0; clk_en = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      i_data = b; i_valid = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_in_ready && clk_en) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      i_valid = 0;
      if (!ok) timeout($sformatf("rx_accept_%0h", b));
   endtask

   task automatic wait_tx(input int n, input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         if (tx_q.size() >= n) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) timeout(name);
      repeat (8) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [31:0] arg;
      int          nrep;
      logic [31:0] rep;
      bit          ewr;
      bit          erd;
      logic [31:0] eaddr;
      logic [31:0] edata;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] op, input logic [31:0] arg, input int nrep,
                               input logic [31:0] rep, input bit ewr, input bit erd,
                               input logic [31:0] eaddr, input logic [31:0] edata);
      vec_t v;
      v.op = op; v.arg = arg; v.nrep = nrep; v.rep = rep;
      v.ewr = ewr; v.erd = erd; v.eaddr = eaddr; v.edata = edata;
      return v;
   endfunction

   localparam int NV = 11;
   vec_t vecs [NV];

   // model state for the randomized phase
   logic [31:0] m_addr;
   logic [31:0] m_mem [logic [31:0]];
   logic [7:0]  e_tx[$];
   logic [31:0] e_wa[$];
   logic [31:0] e_wd[$];
   logic [31:0] e_rd[$];

   initial begin
      int low, enl;
      bit  rst_dropped;

      vecs[0]  = mk(8'h05, 32'h0000_0010, 1, 32'h06, 0, 0, 0, 0);
      vecs[1]  = mk(8'h04, 32'hDEAD_BEEF, 1, 32'h06, 1, 0, 32'h10, 32'hDEAD_BEEF);
      vecs[2]  = mk(8'h05, 32'h0000_0010, 1, 32'h06, 0, 0, 0, 0);
      vecs[3]  = mk(8'h03, 0, 4, 32'hDEAD_BEEF, 0, 1, 32'h10, 0);
      vecs[4]  = mk(8'h03, 0, 4, bg(32'h14), 0, 1, 32'h14, 0);
      vecs[5]  = mk(8'h7F, 0, 1, 32'h15, 0, 0, 0, 0);
      vecs[6]  = mk(8'h00, 0, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(8'h05, 32'hFFFF_FFFC, 1, 32'h06, 0, 0, 0, 0);
      vecs[8]  = mk(8'h04, 32'h1122_3344, 1, 32'h06, 1, 0, 32'hFFFF_FFFC, 32'h1122_3344);
      vecs[9]  = mk(8'h03, 0, 4, bg(32'h0), 0, 1, 32'h0, 0);
      vecs[10] = mk(8'hFF, 0, 1, 32'h15, 0, 0, 0, 0);

      // reset state
      reset_dut();
      repeat (4) @(negedge clk);
      check("rst_cpu_rst", o_cpu_rst, 1);
      check("rst_booted", o_booted, 0);
      check("rst_valid", o_valid, 0);
      check("rst_in_ready", o_in_ready, 1);
      check("rst_data", o_data, 0);
      check("rst_read_req", o_read_req, 0);
      check("rst_write_en", o_write_enable, 0);
      check("rst_cpu_rx_valid", o_cpu_rx_valid, 0);
      check("rst_cpu_tx_ready", o_cpu_tx_ready, 0);

      // directed command table
      ready_mode = 1;
      for (int v = 0; v < NV; v++) begin
         clear_logs();
         send_byte(vecs[v].op);
         if (vecs[v].op == 8'h04 || vecs[v].op == 8'h05)
            for (int k = 0; k < 4; k++) send_byte(vecs[v].arg[8*k +: 8]);
         wait_tx(vecs[v].nrep, $sformatf("v%0d_reply", v));
         check($sformatf("v%0d_reply_len", v), tx_q.size(), vecs[v].nrep);
         for (int k = 0; k < vecs[v].nrep; k++)
            if (k < tx_q.size())
               check($sformatf("v%0d_reply_byte%0d", v, k), tx_q[k], vecs[v].rep[8*k +: 8]);
         check($sformatf("v%0d_write_count", v), wr_addr_q.size(), vecs[v].ewr);
         if (vecs[v].ewr && wr_addr_q.size() > 0) begin
            check($sformatf("v%0d_write_addr", v), wr_addr_q[0], vecs[v].eaddr);
            check($sformatf("v%0d_write_data", v), wr_data_q[0], vecs[v].edata);
            check($sformatf("v%0d_byte_en", v), wr_be_q[0], 4'hF);
         end
         check($sformatf("v%0d_read_count", v), rd_q.size(), vecs[v].erd);
         if (vecs[v].erd && rd_q.size() > 0)
            check($sformatf("v%0d_read_addr", v), rd_q[0], vecs[v].eaddr);
      end

      // RST pulse, with clk_en dropped for three cycles in the middle
      ready_mode = 0;
      send_byte(8'h02);
      low = 0; enl = 0; rst_dropped = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_in_ready) break;
         low++;
         if (clk_en) enl++;
         if (!o_cpu_rst) rst_dropped = 1;
         @(posedge clk); #1;
         clk_en = !(low >= 5 && low < 8);
      end
      clk_en = 1;
      check("pulse_total_cycles", low, RC + 3);
      check("pulse_enabled_cycles", enl, RC);
      check("pulse_cpu_rst_held", rst_dropped, 0);
      @(negedge clk);
      check("pulse_cpu_rst_after", o_cpu_rst, 1);

      // read strobe held off while clk_en is low
      send_byte(8'h05);
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      wait_tx(1, "gate_setaddr_ack");
      clear_logs();
      i_data = 8'h03; i_valid = 1;
      @(negedge clk);
      @(posedge clk); #1;
      i_valid = 0; clk_en = 0;
      @(negedge clk);
      check("gate_rreq_off0", o_read_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("gate_rreq_off1", o_read_req, 0);
      @(posedge clk); #1;
      clk_en = 1;
      @(negedge clk);
      check("gate_rreq_on", o_read_req, 1);
      wait_tx(4, "gate_reply");
      check("gate_read_count", rd_q.size(), 1);
      if (rd_q.size() > 0) check("gate_read_addr", rd_q[0], 32'h40);
      check("gate_reply_len", tx_q.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < tx_q.size()) check($sformatf("gate_byte%0d", k), tx_q[k], bg(32'h40) >> (8*k) & 32'hFF);

      // randomized command stream against the command-level model
      reset_dut();
      ram.delete();
      m_mem.delete();
      m_addr = '0;
      clear_logs();
      ready_mode = 1;
      for (int n = 0; n < 60; n++) begin
         int unsigned kind;
         logic [31:0] a, d;
         kind = $urandom_range(0, 9);
         if (kind <= 1) begin
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'h100 + 32'($urandom_range(0, 15)) * 4;
            send_byte(8'h05);
            for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
            m_addr = a;
            e_tx.push_back(8'h06);
         end else if (kind <= 4) begin
            d = $urandom;
            send_byte(8'h04);
            for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
            e_wa.push_back(m_addr);
            e_wd.push_back(d);
            m_mem[m_addr] = d;
            m_addr = m_addr + 4;
            e_tx.push_back(8'h06);
         end else if (kind <= 7) begin
            send_byte(8'h03);
            d = m_mem.exists(m_addr) ? m_mem[m_addr] : bg(m_addr);
            e_rd.push_back(m_addr);
            for (int k = 0; k < 4; k++) e_tx.push_back(d[8*k +: 8]);
            m_addr = m_addr + 4;
         end else if (kind == 8) begin
            send_byte(8'h00);
         end else begin
            send_byte(8'($urandom_range(6, 255)));
            e_tx.push_back(8'h15);
         end
      end
      wait_tx(e_tx.size(), "rand_reply");
      check("rand_tx_len", tx_q.size(), e_tx.size());
      for (int k = 0; k < e_tx.size(); k++)
         if (k < tx_q.size()) check($sformatf("rand_tx%0d", k), tx_q[k], e_tx[k]);
      check("rand_wr_len", wr_addr_q.size(), e_wa.size());
      for (int k = 0; k < e_wa.size(); k++)
         if (k < wr_addr_q.size()) begin
            check($sformatf("rand_wa%0d", k), wr_addr_q[k], e_wa[k]);
            check($sformatf("rand_wd%0d", k), wr_data_q[k], e_wd[k]);
         end
      check("rand_rd_len", rd_q.size(), e_rd.size());
      for (int k = 0; k < e_rd.size(); k++)
         if (k < rd_q.size()) check($sformatf("rand_ra%0d", k), rd_q[k], e_rd[k]);

      // reset drops a pending NAK byte
      ready_mode = 2;
      i_out_ready = 0;
      send_byte(8'h7F);
      @(negedge clk);
      check("pend_valid", o_valid, 1);
      check("pend_data", o_data, 8'h15);
      reset_dut();
      @(negedge clk);
      check("pend_valid_after_rst", o_valid, 0);
      check("pend_in_ready_after_rst", o_in_ready, 1);

      // reset discards a partial WRITE payload
      ready_mode = 1;
      send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
      reset_dut();
      clear_logs();
      send_byte(8'h03);
      wait_tx(4, "partial_reply");
      check("partial_reply_len", tx_q.size(), 4);
      check("partial_write_count", wr_addr_q.size(), 0);
      check("partial_read_count", rd_q.size(), 1);
      if (rd_q.size() > 0) check("partial_read_addr", rd_q[0], 32'h0);

      // BOOT and pass-through mode
      ready_mode = 2;
      i_out_ready = 1;
      reset_dut();
      send_byte(8'h01);
      @(negedge clk);
      check("boot_cpu_rst", o_cpu_rst, 0);
      check("boot_booted", o_booted, 1);
      @(posedge clk); #1;
      i_cpu_rx_ready = 0;
      @(negedge clk);
      check("boot_in_ready_lo", o_in_ready, 0);
      @(posedge clk); #1;
      i_cpu_rx_ready = 1; i_data = 8'h41; i_valid = 1;
      @(negedge clk);
      check("boot_in_ready_hi", o_in_ready, 1);
      check("boot_rx_data41", o_cpu_rx_data, 8'h41);
      check("boot_rx_valid", o_cpu_rx_valid, 1);
      @(posedge clk); #1;
      i_data = 8'h42;
      @(negedge clk);
      check("boot_rx_data42", o_cpu_rx_data, 8'h42);
      @(posedge clk); #1;
      i_valid = 0; i_cpu_tx_data = 8'h5A; i_cpu_tx_valid = 1; i_out_ready = 1;
      @(negedge clk);
      check("boot_rx_valid_lo", o_cpu_rx_valid, 0);
      check("boot_tx_data", o_data, 8'h5A);
      check("boot_tx_valid", o_valid, 1);
      check("boot_tx_ready_hi", o_cpu_tx_ready, 1);
      @(posedge clk); #1;
      i_out_ready = 0;
      @(negedge clk);
      check("boot_tx_ready_lo", o_cpu_tx_ready, 0);
      @(posedge clk); #1;
      i_cpu_tx_valid = 0;
      clear_logs();
      i_valid = 1;
      i_data = 8'h04; @(posedge clk); #1;
      i_data = 8'hAA; @(posedge clk); #1;
      i_data = 8'hBB; @(posedge clk); #1;
      i_data = 8'hCC; @(posedge clk); #1;
      i_data = 8'hDD; @(posedge clk); #1;
      i_data = 8'h03; @(posedge clk); #1;
      i_valid = 0;
      repeat (10) @(negedge clk);
      check("boot_no_write", wr_addr_q.size(), 0);
      check("boot_no_read", rd_q.size(), 0);
      check("boot_still_booted", o_booted, 1);
      check("boot_no_tx", o_valid, 0);

      // only reset leaves booted mode
      reset_dut();
      @(posedge clk); #1;
      i_valid = 1;
      @(negedge clk);
      check("unboot_booted", o_booted, 0);
      check("unboot_cpu_rst", o_cpu_rst, 1);
      check("unboot_rx_valid", o_cpu_rx_valid, 0);
      @(posedge clk); #1;
      i_valid = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
